// File: rtl/des_pkg.sv
// des_pkg: shared definitions for the DES round controller.
// Contents: FSM state enum, the DES permutation tables (IP, FP, E, P, PC-1,
// PC-2), the eight S-boxes, the 16-entry key-rotation table, and helper
// functions that apply them. Table entry n selects input bit n counted from
// 1 at the MSB, which is the numbering used by the DES standard.
package des_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                               62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                               57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                               61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};

  localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                               38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                               36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                               34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};

  localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13,
                              12,13,14,15,16,17, 16,17,18,19,20,21,
                              20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};

  localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                              2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};

  localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                                10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                                63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                14,6,61,53,45,37,29, 21,13,5,28,20,12,4};

  localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8,
                                16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48,
                                44,49,39,56,34,53, 46,42,50,36,29,32};

  // Each S-box is stored row-major: index = row*16 + column.
  localparam int SBOX_T [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };

  // Left rotation applied to C/D before encrypt round r (entry r-1).
  localparam logic [1:0] SHIFT_T [16] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                          2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

  function automatic logic [63:0] perm_ip(input logic [63:0] x);
    logic [63:0] y;
    y = 64'd0;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
    return y;
  endfunction

  function automatic logic [63:0] perm_fp(input logic [63:0] x);
    logic [63:0] y;
    y = 64'd0;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
    return y;
  endfunction

  function automatic logic [47:0] perm_e(input logic [31:0] x);
    logic [47:0] y;
    y = 48'd0;
    for (int i = 0; i < 48; i++) y[47-i] = x[32-E_T[i]];
    return y;
  endfunction

  function automatic logic [31:0] perm_p(input logic [31:0] x);
    logic [31:0] y;
    y = 32'd0;
    for (int i = 0; i < 32; i++) y[31-i] = x[32-P_T[i]];
    return y;
  endfunction

  function automatic logic [55:0] perm_pc1(input logic [63:0] x);
    logic [55:0] y;
    y = 56'd0;
    for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
    return y;
  endfunction

  function automatic logic [47:0] perm_pc2(input logic [55:0] x);
    logic [47:0] y;
    y = 48'd0;
    for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
    return y;
  endfunction

  // Outer bits pick the row, inner four bits pick the column.
  function automatic logic [3:0] sbox(input int n, input logic [5:0] b);
    int v;
    v = SBOX_T[n][{b[5], b[0], b[4:1]}];
    return v[3:0];
  endfunction

  // Rotate a 28-bit key half by 0..2 places, left or right.
  function automatic logic [27:0] rot28(input logic [27:0] x, input logic [1:0] n,
                                        input logic right);
    logic [27:0] y;
    case ({right, n})
      3'b001:  y = {x[26:0], x[27]};
      3'b010:  y = {x[25:0], x[27:26]};
      3'b101:  y = {x[0], x[27:1]};
      3'b110:  y = {x[1:0], x[27:2]};
      default: y = x;
    endcase
    return y;
  endfunction

  // Decrypt walks the encrypt schedule backwards: no move before round 1,
  // then undo encrypt shifts 16, 15, ... 2 so rounds see K16..K1.
  function automatic logic [1:0] shift_amt(input logic [4:0] rnd, input logic dec);
    logic [1:0] amt;
    amt = 2'd0;
    if (rnd == 5'd0 || rnd > 5'd16) amt = 2'd0;
    else if (!dec)                  amt = SHIFT_T[int'(rnd) - 1];
    else if (rnd == 5'd1)           amt = 2'd0;
    else                            amt = SHIFT_T[17 - int'(rnd)];
    return amt;
  endfunction

endpackage

// File: rtl/des_round.sv
// des_round: one combinational DES Feistel round.
// Ports: i_l, i_r   32-bit halves entering the round
//        i_subkey   48-bit round key
//        o_l, o_r   halves leaving the round: o_l = i_r, o_r = i_l ^ f(i_r, i_subkey)
module des_round
  import des_pkg::*;
(
  input  logic [31:0] i_l,
  input  logic [31:0] i_r,
  input  logic [47:0] i_subkey,
  output logic [31:0] o_l,
  output logic [31:0] o_r
);

  logic [47:0] w_mix;
  logic [31:0] w_sbox;

  // Expansion, key mix and S-box substitution of the right half
  always_comb begin
    w_mix  = perm_e(i_r) ^ i_subkey;
    w_sbox = 32'd0;
    for (int i = 0; i < 8; i++) begin
      w_sbox[31-4*i -: 4] = sbox(i, w_mix[47-6*i -: 6]);
    end
  end

  assign o_l = i_r;
  assign o_r = i_l ^ perm_p(w_sbox);

endmodule

// File: rtl/des_round_ctrl.sv
// des_round_ctrl: iterative DES engine, one Feistel round per clock, using a
// single shared des_round instance.
// Ports: clk, rst_n (async active-low); in_valid/in_ready accept handshake for
//        in (64-bit block), k (64-bit key with parity) and decrypt (mode);
//        out_valid/out_ready result handshake for out (64-bit, held until taken);
//        round_idx shows the round being executed (1..ROUNDS), 0 otherwise.
// Option: define DES_CBC_EN to add iv/iv_load and a CBC chain register.
module des_round_ctrl
  import des_pkg::*;
#(
  parameter int ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        decrypt,
  input  logic [63:0] k,
  input  logic [63:0] in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out,
`ifdef DES_CBC_EN
  input  logic [63:0] iv,
  input  logic        iv_load,
`endif
  output logic [4:0]  round_idx
);

  localparam logic [4:0] LAST_RND = 5'(ROUNDS);

  state_e      r_state, w_state_nxt;
  logic [31:0] r_l, r_r;
  logic [27:0] r_c, r_d;
  logic        r_dec;
  logic [4:0]  r_round;
  logic [63:0] r_out;

  logic        w_accept, w_last;
  logic [1:0]  w_rot;
  logic [27:0] w_c_next, w_d_next;
  logic [47:0] w_subkey;
  logic [31:0] w_l_next, w_r_next;
  logic [63:0] w_blk_in, w_fp, w_result;

`ifdef DES_CBC_EN
  logic [63:0] r_chain;
  logic [63:0] r_blk_in;   // block as received, becomes the chain after a decrypt
  assign w_blk_in = decrypt ? in : (in ^ r_chain);
  assign w_result = r_dec ? (w_fp ^ r_chain) : w_fp;
`else
  assign w_blk_in = in;
  assign w_result = w_fp;
`endif

  assign w_accept = in_valid & in_ready;
  assign w_last   = (r_round == LAST_RND);

  // Key schedule: rotate C/D for the current round and derive the subkey
  always_comb begin
    w_rot    = shift_amt(r_round, r_dec);
    w_c_next = rot28(r_c, w_rot, r_dec);
    w_d_next = rot28(r_d, w_rot, r_dec);
    w_subkey = perm_pc2({w_c_next, w_d_next});
  end

  des_round u_round (
    .i_l      (r_l),
    .i_r      (r_r),
    .i_subkey (w_subkey),
    .o_l      (w_l_next),
    .o_r      (w_r_next)
  );

  // No swap after the last round: the output halves go in as {R, L}
  assign w_fp = perm_fp({w_r_next, w_l_next});

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept)  w_state_nxt = ST_ROUND; else w_state_nxt = ST_IDLE;
      ST_ROUND: if (w_last)    w_state_nxt = ST_DONE;  else w_state_nxt = ST_ROUND;
      ST_DONE:  if (out_ready) w_state_nxt = ST_IDLE;  else w_state_nxt = ST_DONE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
`ifdef DES_CBC_EN
      ST_IDLE:  in_ready  = ~iv_load;   // IV load wins over an accept
`else
      ST_IDLE:  in_ready  = 1'b1;
`endif
      ST_DONE:  out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Datapath: load on accept, one round per ROUND cycle, capture result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_l     <= 32'd0;
      r_r     <= 32'd0;
      r_c     <= 28'd0;
      r_d     <= 28'd0;
      r_dec   <= 1'b0;
      r_round <= 5'd0;
      r_out   <= 64'd0;
`ifdef DES_CBC_EN
      r_chain  <= 64'd0;
      r_blk_in <= 64'd0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
`ifdef DES_CBC_EN
          if (iv_load) r_chain <= iv;
`endif
          if (w_accept) begin
            {r_l, r_r} <= perm_ip(w_blk_in);
            {r_c, r_d} <= perm_pc1(k);
            r_dec      <= decrypt;
            r_round    <= 5'd1;
`ifdef DES_CBC_EN
            r_blk_in   <= in;
`endif
          end
        end
        ST_ROUND: begin
          r_l <= w_l_next;
          r_r <= w_r_next;
          r_c <= w_c_next;
          r_d <= w_d_next;
          if (w_last) begin
            r_round <= 5'd0;
            r_out   <= w_result;
          end else begin
            r_round <= r_round + 5'd1;
          end
        end
        ST_DONE: begin
`ifdef DES_CBC_EN
          if (out_ready) r_chain <= r_dec ? r_blk_in : r_out;
`endif
        end
        default: r_round <= 5'd0;
      endcase
    end
  end

  assign out       = r_out;
  assign round_idx = r_round;

endmodule

// File: doc/des_round_ctrl.md
DES_ROUND_CTRL -- requirements
Module: des_round_ctrl

Interface
REQ-001 SHALL have parameter ROUNDS, default 16, number of Feistel rounds executed, legal 1..16; test use only below 16.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  block and key offered.
REQ-005 SHALL have port in_ready  output  1  controller can accept a block.
REQ-006 SHALL have port decrypt  input  1  mode, sampled with block: 0 encrypt, 1 decrypt.
REQ-007 SHALL have port k  input  64  DES key including parity bits, sampled with block.
REQ-008 SHALL have port in  input  64  plaintext or ciphertext, sampled with block.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port out  output  64  result block.
REQ-012 SHALL have port round_idx  output  5  current round number 1..16, 0 when not in ROUND.

Function
REQ-013 SHALL implement FSM IDLE -> ROUND -> DONE -> IDLE, one round per clock.
REQ-014 SHALL assert in_ready only in IDLE; accept occurs on in_valid & in_ready.
REQ-015 On accept SHALL load L/R from the initial permutation of in, C/D from PC-1 of k, latch decrypt, and enter ROUND with round_idx=1.
REQ-016 Each ROUND cycle SHALL compute the subkey via PC-2 of shifted C/D, apply one round (L'=R, R'=L^f(R,subkey)), and increment round_idx.
REQ-017 Encrypt key schedule SHALL rotate C/D left before round r by 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-018 Decrypt key schedule SHALL rotate C/D right after PC-1 by 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 before round r, yielding subkeys K16..K1.
REQ-019 After round ROUNDS SHALL enter DONE; out SHALL be final permutation of {R,L} (no swap after last round).
REQ-020 SHALL assert out_valid only in DONE; out SHALL be held stable until out_valid & out_ready.
REQ-021 Latency: accept at edge N SHALL give out_valid high after edge N+ROUNDS.
REQ-022 On out_valid & out_ready SHALL return to IDLE; in_ready rises the following cycle, so no back-to-back accept in that cycle.
REQ-023 in_valid, k, in, decrypt changes during ROUND/DONE SHALL be ignored.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, in_ready=1 after release, out_valid=0, out=0, round_idx=0, and clear L/R/C/D and any chaining register.
REQ-025 Reset asserted mid-ROUND SHALL abort the block with no output ever produced for it.

Configuration
REQ-026 Macro DES_CBC_EN, when defined, SHALL add ports iv (input 64) and iv_load (input 1) and a 64-bit chain register; iv_load in IDLE SHALL load chain=iv (iv_load has priority over accept in same cycle, in_ready low that cycle).
REQ-027 With DES_CBC_EN: encrypt SHALL process in^chain and set chain=out on handoff; decrypt SHALL output result^chain and set chain=in of that block on handoff.
REQ-028 Without DES_CBC_EN, iv/iv_load and chain register SHALL not exist; behaviour is ECB per REQ-013..REQ-023.

Structure
REQ-029 Package des_pkg SHALL hold IP, FP, E, P, PC-1, PC-2, S-box tables, the 16-entry shift table, and the FSM state enum.
REQ-030 Sub-module des_round SHALL be combinational: inputs L, R, 48-bit subkey; outputs next L, R (expansion, key mix, S-boxes, P, XOR).
REQ-031 Controller SHALL instantiate exactly one des_round, reused every round.

Verification
REQ-032 Encrypt k=133457799BBCDFF1, in=0123456789ABCDEF -> out=85E813540F0AB405, out_valid 16 cycles after accept.
REQ-033 Decrypt same k, in=85E813540F0AB405 -> out=0123456789ABCDEF; round_idx steps 1..16 then 0.
REQ-034 out_ready held low 5 cycles in DONE -> out stable, in_ready low, new in_valid ignored; then out_ready high -> IDLE next cycle.
REQ-035 rst_n pulsed low at round 7 -> out_valid never asserts for that block, next block 0123456789ABCDEF encrypts correctly.
REQ-036 DES_CBC_EN: iv=0000000000000000, two encrypts of 0123456789ABCDEF -> first 85E813540F0AB405, second equals ECB of 0123456789ABCDEF^85E813540F0AB405; decrypting both with same iv restores plaintexts.
